// File: rtl/barrier_gate_ctrl.sv
// ============================================================================
//  Module   : barrier_gate_ctrl
//  Purpose  : Shared parking barrier controller for an entry and an exit lane,
//             with occupancy tracking. Optional macro RR_ARB_EN selects
//             round-robin arbitration instead of fixed exit priority.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module barrier_gate_ctrl #(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MatrVal_In,
    input  logic [23:0]      Matricula_In,
    input  logic             MatrVal_Out,
    input  logic [23:0]      Matricula_Out,
    input  logic [6:0]       Q6,
    input  logic             Sensor,
    output logic             Barreira,
    output logic             Dir,
    output logic [23:0]      Matricula_Atual,
    output logic [CNT_W-1:0] Lugares,
    output logic             Cheio,
    output logic             Busy_In,
    output logic             Busy_Out,
    output logic             Passou,
    output logic             Timeout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OPEN  = 2'd1;
    localparam logic [1:0] c_CLOSE = 2'd2;

    localparam logic [CNT_W-1:0] c_CAP  = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    logic [1:0]       r_state;
    logic [6:0]       r_cnt;
    logic             r_barreira;
    logic             r_dir;
    logic [23:0]      r_mat_atual;
    logic [CNT_W-1:0] r_lugares;
    logic             r_passou;
    logic             r_timeout;
    logic             r_busy_in;
    logic             r_busy_out;
    logic [23:0]      r_plate_in;
    logic [23:0]      r_plate_out;

    logic w_cheio;
    logic w_elig_in;
    logic w_elig_out;
    logic w_pick_in;
    logic w_pick_out;
    logic w_idle;
    logic w_grant_in;
    logic w_grant_out;
    logic w_grant;

    assign w_cheio    = (r_lugares == c_CAP);
    assign w_elig_in  = r_busy_in & ~w_cheio;
    assign w_elig_out = r_busy_out;

`ifdef RR_ARB_EN
    // r_dir holds the last granted lane; on a tie the other lane wins.
    assign w_pick_in  = w_elig_in & (~w_elig_out | ~r_dir);
`else
    // Exit wins ties: it frees a space that a blocked entry may need.
    assign w_pick_in  = w_elig_in & ~w_elig_out;
`endif
    assign w_pick_out = w_elig_out & ~w_pick_in;

    assign w_idle      = (r_state == c_IDLE);
    assign w_grant_in  = w_idle & w_pick_in;
    assign w_grant_out = w_idle & w_pick_out;
    assign w_grant     = w_grant_in | w_grant_out;

    // Strobes arriving while a lane is pending (including its grant cycle) are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy_in  <= 1'b0;
            r_plate_in <= 24'd0;
        end else if (w_grant_in) begin
            r_busy_in  <= 1'b0;
        end else if (MatrVal_In && !r_busy_in) begin
            r_busy_in  <= 1'b1;
            r_plate_in <= Matricula_In;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy_out  <= 1'b0;
            r_plate_out <= 24'd0;
        end else if (w_grant_out) begin
            r_busy_out  <= 1'b0;
        end else if (MatrVal_Out && !r_busy_out) begin
            r_busy_out  <= 1'b1;
            r_plate_out <= Matricula_Out;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_cnt       <= 7'd0;
            r_barreira  <= 1'b0;
            r_dir       <= 1'b0;
            r_mat_atual <= 24'd0;
            r_lugares   <= c_ZERO;
            r_passou    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_passou  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_state     <= c_OPEN;
                        r_barreira  <= 1'b1;
                        r_cnt       <= Q6;
                        r_dir       <= w_grant_in;
                        r_mat_atual <= w_grant_in ? r_plate_in : r_plate_out;
                    end
                end
                c_OPEN: begin
                    // A pass in the final open cycle still counts as a pass.
                    if (Sensor) begin
                        r_passou   <= 1'b1;
                        r_barreira <= 1'b0;
                        r_state    <= c_CLOSE;
                        if (r_dir) begin
                            r_lugares <= r_lugares + c_ONE;
                        end else if (r_lugares != c_ZERO) begin
                            r_lugares <= r_lugares - c_ONE;
                        end
                    end else if (r_cnt == 7'd0) begin
                        r_timeout  <= 1'b1;
                        r_barreira <= 1'b0;
                        r_state    <= c_CLOSE;
                    end else begin
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                c_CLOSE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_barreira <= 1'b0;
                end
            endcase
        end
    end

    assign Barreira        = r_barreira;
    assign Dir             = r_dir;
    assign Matricula_Atual = r_mat_atual;
    assign Lugares         = r_lugares;
    assign Cheio           = w_cheio;
    assign Busy_In         = r_busy_in;
    assign Busy_Out        = r_busy_out;
    assign Passou          = r_passou;
    assign Timeout         = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_barrier_gate_ctrl.sv
// ============================================================================
//  Module   : tb_barrier_gate_ctrl
//  Purpose  : Directed self-checking bench for barrier_gate_ctrl with a grant
//             scoreboard (expected lane/plate queued at request time).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_barrier_gate_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MatrVal_In = 1'b0;
    logic [23:0] Matricula_In = 24'd0;
    logic        MatrVal_Out = 1'b0;
    logic [23:0] Matricula_Out = 24'd0;
    logic [6:0]  Q6 = 7'd0;
    logic        Sensor = 1'b0;
    logic        Barreira;
    logic        Dir;
    logic [23:0] Matricula_Atual;
    logic [4:0]  Lugares;
    logic        Cheio;
    logic        Busy_In;
    logic        Busy_Out;
    logic        Passou;
    logic        Timeout;

    barrier_gate_ctrl #(.CAPACITY(16), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .MatrVal_In(MatrVal_In), .Matricula_In(Matricula_In),
        .MatrVal_Out(MatrVal_Out), .Matricula_Out(Matricula_Out),
        .Q6(Q6), .Sensor(Sensor),
        .Barreira(Barreira), .Dir(Dir), .Matricula_Atual(Matricula_Atual),
        .Lugares(Lugares), .Cheio(Cheio),
        .Busy_In(Busy_In), .Busy_Out(Busy_Out),
        .Passou(Passou), .Timeout(Timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        dir;
        logic [23:0] plate;
    } grant_t;

    grant_t exp_q[$];
    grant_t mon_g;
    logic   prev_bar = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     n;
    int     k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic req_in(input logic [23:0] p, input logic push);
        grant_t g;
        MatrVal_In   = 1'b1;
        Matricula_In = p;
        if (push) begin
            g.dir = 1'b1; g.plate = p;
            exp_q.push_back(g);
        end
        step();
        MatrVal_In = 1'b0;
    endtask

    task automatic req_out(input logic [23:0] p, input logic push);
        grant_t g;
        MatrVal_Out   = 1'b1;
        Matricula_Out = p;
        if (push) begin
            g.dir = 1'b0; g.plate = p;
            exp_q.push_back(g);
        end
        step();
        MatrVal_Out = 1'b0;
    endtask

    // Waits for the barrier to open (k = cycles waited), then counts open cycles (n),
    // raising Sensor in open cycle sensor_at (0 = never). Returns in the CLOSE cycle.
    task automatic run_open(input int sensor_at, output int on, output int ok);
        ok = 0;
        while (Barreira !== 1'b1 && ok < 40) begin
            step();
            ok++;
        end
        chk("open_seen", {31'd0, Barreira}, 32'd1);
        on = 0;
        while (Barreira === 1'b1 && on < 200) begin
            on++;
            Sensor = (on == sensor_at);
            step();
        end
        Sensor = 1'b0;
    endtask

    // Scoreboard: every barrier opening must match the oldest queued grant.
    always @(negedge CLK) begin
        if (Barreira === 1'b1 && prev_bar !== 1'b1) begin
            chk("grant_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_g = exp_q.pop_front();
                chk("grant_dir", {31'd0, Dir}, {31'd0, mon_g.dir});
                chk("grant_plate", {8'd0, Matricula_Atual}, {8'd0, mon_g.plate});
            end
        end
        prev_bar = Barreira;
    end

    initial begin
        // Reset state
        RST = 1'b1;
        step();
        step();
        chk("rst_barreira", {31'd0, Barreira}, 32'd0);
        chk("rst_dir", {31'd0, Dir}, 32'd0);
        chk("rst_lugares", {27'd0, Lugares}, 32'd0);
        chk("rst_plate", {8'd0, Matricula_Atual}, 32'd0);
        chk("rst_busy", {30'd0, Busy_In, Busy_Out}, 32'd0);
        chk("rst_pulses", {30'd0, Passou, Timeout}, 32'd0);
        chk("rst_cheio", {31'd0, Cheio}, 32'd0);
        RST = 1'b0;
        step();

        // Entry, Q6=3, no pass: 4 open cycles then timeout
        Q6 = 7'd3;
        req_in(24'hABC123, 1'b1);
        chk("a_busy_in", {31'd0, Busy_In}, 32'd1);
        chk("a_bar_pre", {31'd0, Barreira}, 32'd0);
        run_open(0, n, k);
        chk("a_latency", k, 32'd1);
        chk("a_open_len", n, 32'd4);
        chk("a_timeout", {31'd0, Timeout}, 32'd1);
        chk("a_passou", {31'd0, Passou}, 32'd0);
        chk("a_dir", {31'd0, Dir}, 32'd1);
        chk("a_plate", {8'd0, Matricula_Atual}, 32'h00ABC123);
        chk("a_lugares", {27'd0, Lugares}, 32'd0);
        chk("a_busy_clr", {31'd0, Busy_In}, 32'd0);
        step();
        chk("a_guard_bar", {31'd0, Barreira}, 32'd0);
        chk("a_timeout_pulse", {31'd0, Timeout}, 32'd0);

        // Entry, Q6=10, pass in 3rd open cycle
        Q6 = 7'd10;
        req_in(24'h111111, 1'b1);
        run_open(3, n, k);
        chk("b_open_len", n, 32'd3);
        chk("b_passou", {31'd0, Passou}, 32'd1);
        chk("b_timeout", {31'd0, Timeout}, 32'd0);
        chk("b_lugares", {27'd0, Lugares}, 32'd1);
        step();
        chk("b_passou_pulse", {31'd0, Passou}, 32'd0);
        chk("b_guard_bar", {31'd0, Barreira}, 32'd0);

        // Five more entries then one exit: Lugares=5, last grant = exit
        Q6 = 7'd0;
        for (int i = 0; i < 5; i++) begin
            req_in(24'h200000 + 24'(i), 1'b1);
            run_open(1, n, k);
            step();
        end
        chk("fill_lugares6", {27'd0, Lugares}, 32'd6);
        req_out(24'h300000, 1'b1);
        run_open(1, n, k);
        chk("exit_lugares5", {27'd0, Lugares}, 32'd5);
        step();

        // Simultaneous requests
        MatrVal_In = 1'b1;  Matricula_In = 24'h000001;
        MatrVal_Out = 1'b1; Matricula_Out = 24'h000002;
`ifdef RR_ARB_EN
        exp_q.push_back(grant_t'({1'b1, 24'h000001}));
        exp_q.push_back(grant_t'({1'b0, 24'h000002}));
`else
        exp_q.push_back(grant_t'({1'b0, 24'h000002}));
        exp_q.push_back(grant_t'({1'b1, 24'h000001}));
`endif
        step();
        MatrVal_In = 1'b0;
        MatrVal_Out = 1'b0;
        chk("c_both_busy", {30'd0, Busy_In, Busy_Out}, 32'd3);
        run_open(1, n, k);
`ifdef RR_ARB_EN
        chk("c_lug_first", {27'd0, Lugares}, 32'd6);
`else
        chk("c_lug_first", {27'd0, Lugares}, 32'd4);
`endif
        run_open(1, n, k);
        chk("c_gap", k, 32'd2);
        chk("c_lug_second", {27'd0, Lugares}, 32'd5);
        step();

        // Fill to capacity
        for (int i = 0; i < 11; i++) begin
            req_in(24'h400000 + 24'(i), 1'b1);
            run_open(1, n, k);
            step();
        end
        chk("full_lugares", {27'd0, Lugares}, 32'd16);
        chk("full_cheio", {31'd0, Cheio}, 32'd1);

        // Blocked entry stays pending; a second strobe is dropped
        req_in(24'hF00D00, 1'b0);
        repeat (5) step();
        chk("blk_busy", {31'd0, Busy_In}, 32'd1);
        chk("blk_bar", {31'd0, Barreira}, 32'd0);
        req_in(24'hBAD000, 1'b0);
        step();
        chk("blk_busy2", {31'd0, Busy_In}, 32'd1);
        req_out(24'h500000, 1'b1);
        exp_q.push_back(grant_t'({1'b1, 24'hF00D00}));
        run_open(1, n, k);
        chk("blk_lug15", {27'd0, Lugares}, 32'd15);
        chk("blk_cheio0", {31'd0, Cheio}, 32'd0);
        chk("blk_still_busy", {31'd0, Busy_In}, 32'd1);
        run_open(1, n, k);
        chk("blk_gap", k, 32'd2);
        chk("blk_plate", {8'd0, Matricula_Atual}, 32'h00F00D00);
        chk("blk_lug16", {27'd0, Lugares}, 32'd16);
        step();

        // Reset during the 2nd open cycle, with an entry pending
        Q6 = 7'd10;
        req_out(24'h123456, 1'b1);
        step();
        chk("r_open1", {31'd0, Barreira}, 32'd1);
        MatrVal_In = 1'b1; Matricula_In = 24'h777777;
        step();
        MatrVal_In = 1'b0;
        chk("r_pending", {31'd0, Busy_In}, 32'd1);
        RST = 1'b1;
        #1;
        chk("r_bar_async", {31'd0, Barreira}, 32'd0);
        chk("r_lugares", {27'd0, Lugares}, 32'd0);
        chk("r_busy", {30'd0, Busy_In, Busy_Out}, 32'd0);
        chk("r_dir_plate", {7'd0, Dir, Matricula_Atual}, 32'd0);
        chk("r_pulses", {29'd0, Passou, Timeout, Cheio}, 32'd0);
        step();
        RST = 1'b0;
        repeat (4) step();
        chk("r_stays_closed", {31'd0, Barreira}, 32'd0);

        // Exit with pass at Lugares=0 saturates
        Q6 = 7'd2;
        req_out(24'h0E0E0E, 1'b1);
        run_open(1, n, k);
        chk("s_passou", {31'd0, Passou}, 32'd1);
        chk("s_lugares", {27'd0, Lugares}, 32'd0);
        step();

        // Q6=0 with pass in the only open cycle
        Q6 = 7'd0;
        req_in(24'h00C0DE, 1'b1);
        run_open(1, n, k);
        chk("q0_open_len", n, 32'd1);
        chk("q0_pulses", {30'd0, Passou, Timeout}, 32'd2);
        chk("q0_lugares", {27'd0, Lugares}, 32'd1);
        step();

        // Q6 changed after grant does not stretch the current opening
        Q6 = 7'd0;
        req_in(24'h0C0C0C, 1'b1);
        step();
        Q6 = 7'd20;
        run_open(0, n, k);
        chk("qc_open_len", n, 32'd1);
        chk("qc_timeout", {31'd0, Timeout}, 32'd1);
        chk("qc_lugares", {27'd0, Lugares}, 32'd1);
        step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
